// File: rtl/bcd2bin_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd2bin_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int BCD_DIGIT_W = 4;

    // A digit at or above ADJ_THRESH after a right shift carried a
    // weight-10 half from its upper neighbour and must drop by ADJ_SUB.
    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd8;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_SUB    = 4'd3;
    localparam logic [BCD_DIGIT_W-1:0] DIGIT_MAX  = 4'd9;

    // True when a nibble is not a legal decimal digit.
    function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
        return (d > DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd2bin_digit_adj.sv
// Per-digit correction step of reverse double-dabble.
module bcd_digit_adj
    import bcd2bin_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    // Subtract 3 from any digit that reads 8 or more after the shift.
    always_comb begin
        o_digit = (i_digit >= ADJ_THRESH) ? (i_digit - ADJ_SUB) : i_digit;
    end

endmodule

// File: rtl/bcd2bin.sv
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble).
// One right shift of {bcd, bin} per clock, then per-digit correction.
module bcd2bin
    import bcd2bin_pkg::*;
#(
    parameter  int N_DIGITS = 4,
    localparam int BIN_W    = $clog2(10**N_DIGITS)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [4*N_DIGITS-1:0]       i_bcd,
    output logic [BIN_W-1:0]            o_bin,
    output logic                        o_ready,
    output logic                        o_done,
    output logic                        o_err
);

    localparam int BCD_W = BCD_DIGIT_W * N_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_e             state_q, state_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic               err_q, err_d;

    logic [BCD_W-1:0]   bcd_shr;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BIN_W-1:0]   bin_shr;
    logic [N_DIGITS-1:0] digit_bad;
    logic               any_bad;
    logic               accept;
    logic               last_shift;

    // Whole working register moves right by one; the BCD LSB feeds the binary MSB.
    assign bcd_shr = {1'b0, bcd_q[BCD_W-1:1]};
    assign bin_shr = {bcd_q[0], bin_q[BIN_W-1:1]};

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
        bcd_digit_adj u_adj (
            .i_digit (bcd_shr[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
        assign digit_bad[g] = digit_invalid(i_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end

    assign any_bad    = |digit_bad;
    assign accept     = (state_q == IDLE) && i_start;
    assign last_shift = (n_q == CNT_W'(1));

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: invalid input bypasses OP entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = any_bad ? DONE : OP;
                end
            end
            OP: begin
                if (last_shift) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        o_ready = (state_q == IDLE);
        o_done  = (state_q == DONE);
    end

    // Datapath next-state: load on accept, shift-and-correct while in OP.
    always_comb begin
        bcd_d = bcd_q;
        bin_d = bin_q;
        n_d   = n_q;
        err_d = err_q;
        if (accept) begin
            bcd_d = i_bcd;
            bin_d = '0;
            n_d   = CNT_W'(BIN_W);
            err_d = any_bad;
        end else if (state_q == OP) begin
            bcd_d = bcd_adj;
            bin_d = bin_shr;
            n_d   = n_q - CNT_W'(1);
        end
    end

    // Datapath registers; reset clears any partial result.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bcd_q <= '0;
            bin_q <= '0;
            n_q   <= '0;
            err_q <= 1'b0;
        end else begin
            bcd_q <= bcd_d;
            bin_q <= bin_d;
            n_q   <= n_d;
            err_q <= err_d;
        end
    end

    assign o_bin = bin_q;
    assign o_err = err_q;

endmodule
